// File: rtl/spi_regfile_pkg.sv
// Shared types and sizes for the SPI slave register file.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 2;
    localparam int DATA_W        = 8;
    localparam int NUM_REGS      = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// pulses taken from one extra flop on the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~last_q;
    assign fall = ~dout & last_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave owning the four display registers: command byte, then
// data bytes with address auto-increment, all in the clk domain.
module spi_slave_regfile
    import spi_regfile_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] REG_RESET  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] slv_reg0,
    output logic [DATA_W-1:0] slv_reg1,
    output logic [DATA_W-1:0] slv_reg2,
    output logic [DATA_W-1:0] slv_reg3,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_n_s, ss_rise, ss_fall;
    logic sync_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .reset(reset), .din(sclk),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk (clk), .reset(reset), .din(ss_n),
        .dout(ss_n_s), .rise(ss_rise), .fall(ss_fall)
    );

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [DATA_W-2:0]   rx_shift;
    logic [DATA_W-1:0]   rx_next;
    logic [DATA_W-1:0]   tx_shift;
    logic                rw_write;
    logic                shift_en;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic                wr_pending;
    logic [DATA_W-1:0]   wr_data;
    logic                armed;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settled;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    assign rx_next  = {rx_shift, mosi_s};
    assign addr_inc = addr + ADDR_W'(1);
    assign settled  = (settle_cnt == SETTLE_W'(SYNC_STAGES));

    assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall, ss_rise, ss_fall,
                           rx_next[CMD_WRITE_BIT-1:ADDR_W]};

    // A frame may only start once ss_n has been seen high after reset, so a
    // frame that was cut by reset is never picked up half way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rw_write   <= 1'b0;
            shift_en   <= 1'b0;
            addr       <= '0;
            wr_pending <= 1'b0;
            wr_data    <= '0;
            wr_pulse   <= 1'b0;
            wr_addr    <= '0;
            armed      <= 1'b0;
            settle_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_RESET;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (!settled) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
            if (settled && ss_n_s) begin
                armed <= 1'b1;
            end

            if (wr_pending) begin
                wr_pending <= 1'b0;
                regs[addr] <= wr_data;
                wr_pulse   <= 1'b1;
                wr_addr    <= addr;
                addr       <= addr_inc;
            end

            if (ss_n_s) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                shift_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state    <= CMD;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next[DATA_W-2:0];
                            if (bit_cnt == 3'(DATA_W - 1)) begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                rw_write <= rx_next[CMD_WRITE_BIT];
                                addr     <= rx_next[ADDR_W-1:0];
                                shift_en <= 1'b0;
                                if (!rx_next[CMD_WRITE_BIT]) begin
                                    tx_shift <= regs[rx_next[ADDR_W-1:0]];
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (rw_write) begin
                            if (sclk_rise) begin
                                rx_shift <= rx_next[DATA_W-2:0];
                                if (bit_cnt == 3'(DATA_W - 1)) begin
                                    bit_cnt    <= '0;
                                    wr_pending <= 1'b1;
                                    wr_data    <= rx_next;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end else begin
                            // The fall right after a reload must not shift, or
                            // the MSB of the next byte would be lost.
                            if (sclk_rise) begin
                                if (bit_cnt == 3'(DATA_W - 1)) begin
                                    bit_cnt  <= '0;
                                    addr     <= addr_inc;
                                    tx_shift <= regs[addr_inc];
                                    shift_en <= 1'b0;
                                end else begin
                                    bit_cnt  <= bit_cnt + 3'd1;
                                    shift_en <= 1'b1;
                                end
                            end else if (sclk_fall && shift_en) begin
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign miso     = (state == DATA) && !rw_write && !ss_n_s && tx_shift[DATA_W-1];
    assign miso_oe  = ~ss_n_s;
    assign busy     = ~ss_n_s;
    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: directed frames, abort, reset
// mid-frame and a run of random read/write frames at clk/sclk = 8.
module tb_spi_slave_regfile;

    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic       wr_pulse;
    logic [1:0] wr_addr;
    logic       busy;

    spi_slave_regfile #(.SYNC_STAGES(SYNC_STAGES), .REG_RESET(8'h00)) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso),
        .miso_oe (miso_oe),
        .slv_reg0(slv_reg0),
        .slv_reg1(slv_reg1),
        .slv_reg2(slv_reg2),
        .slv_reg3(slv_reg3),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         wr_seen = 0;
    int         exp_wr_count = 0;
    logic [7:0] model [4];
    logic [9:0] exp_wr [$];
    logic [7:0] rd_exp [$];
    logic [7:0] rd_obs [$];
    logic [7:0] frame_q [$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input logic [1:0] a);
        case (a)
            2'd0:    return slv_reg0;
            2'd1:    return slv_reg1;
            2'd2:    return slv_reg2;
            default: return slv_reg3;
        endcase
    endfunction

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("slv_reg%0d", i), reg_at(2'(i)), model[i]);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT strobes a write or the
    // master has collected a read byte.
    always @(negedge clk) begin
        logic [9:0] e;
        if (reset && wr_pulse) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                check_output("wr_pulse_unexpected", wr_pulse, 1'b0);
            end else begin
                e = exp_wr.pop_front();
                check_output("wr_addr", wr_addr, e[9:8]);
                check_output("wr_data", reg_at(wr_addr), e[7:0]);
            end
        end
        if (rd_obs.size() > 0 && rd_exp.size() > 0) begin
            check_output("rd_byte", rd_obs.pop_front(), rd_exp.pop_front());
        end
    end

    // Mode-0 master: mosi changes after a skewed delay in the low phase,
    // miso is sampled right at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        int off;
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            off = $urandom_range(1, 6);
            #(off) mosi = tx[i];
            #(40 - off);
            rx[i] = miso;
            sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic is_write, input logic [1:0] start,
                                  input int nbytes, input int tail_bits);
        logic [7:0] cmd, rx, d;
        logic [1:0] a;
        cmd = {is_write, 5'($urandom), start};
        a = start;
        for (int i = 0; i < nbytes; i++) begin
            if (is_write) begin
                model[a] = frame_q[i];
                exp_wr.push_back({a, frame_q[i]});
                exp_wr_count++;
            end else begin
                rd_exp.push_back(model[a]);
            end
            a = a + 2'd1;
        end
        @(negedge clk);
        ss_n = 1'b0;
        #(10 * $urandom_range(1, 3) + $urandom_range(0, 3));
        spi_bits(cmd, 8, rx);
        check_output("miso_during_cmd", rx, 8'h00);
        check_output("miso_oe_in_frame", miso_oe, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            d = is_write ? frame_q[i] : 8'($urandom);
            spi_bits(d, 8, rx);
            if (!is_write) rd_obs.push_back(rx);
        end
        if (tail_bits > 0) spi_bits(frame_q[nbytes], tail_bits, rx);
        #($urandom_range(10, 30));
        ss_n = 1'b1;
        for (int k = 0; k < SYNC_STAGES + 1 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        check_output("busy_release", busy, 1'b0);
        #100;
    endtask

    initial begin
        logic [7:0] rx;
        reset = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        ss_n  = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        #12;
        check_output("rst_slv_reg0", slv_reg0, 8'h00);
        check_output("rst_slv_reg3", slv_reg3, 8'h00);
        check_output("rst_wr_pulse", wr_pulse, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_miso_oe", miso_oe, 1'b0);
        check_output("rst_miso", miso, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single write to register 1.
        frame_q = {8'hA5};
        apply_stimulus(1'b1, 2'd1, 1, 0);
        check_output("single_slv_reg1", slv_reg1, 8'hA5);
        check_output("single_slv_reg0", slv_reg0, 8'h00);
        check_output("single_wr_count", wr_seen, 1);
        check_regs();

        // Burst write wrapping 3 -> 0 -> 1.
        frame_q = {8'h11, 8'h22, 8'h33};
        apply_stimulus(1'b1, 2'd3, 3, 0);
        check_output("burst_slv_reg3", slv_reg3, 8'h11);
        check_output("burst_slv_reg0", slv_reg0, 8'h22);
        check_output("burst_slv_reg1", slv_reg1, 8'h33);
        check_output("burst_wr_count", wr_seen, 4);

        // Read back register 2 after preloading it.
        frame_q = {8'h5C};
        apply_stimulus(1'b1, 2'd2, 1, 0);
        apply_stimulus(1'b0, 2'd2, 1, 0);
        check_output("read_no_wr", wr_seen, 5);

        // Abort after five bits of a data byte.
        frame_q = {8'h3C};
        apply_stimulus(1'b1, 2'd0, 0, 5);
        check_output("abort_slv_reg0", slv_reg0, 8'h22);
        check_output("abort_no_wr", wr_seen, 5);
        check_regs();

        // Async reset in the middle of a burst, then a frame that must not resume.
        frame_q = {8'hFF};
        apply_stimulus(1'b1, 2'd0, 1, 0);
        check_output("pre_reset_slv_reg0", slv_reg0, 8'hFF);
        @(negedge clk);
        ss_n = 1'b0;
        #20;
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h3C, 3, rx);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_slv_reg0", slv_reg0, 8'h00);
        check_output("mid_rst_slv_reg1", slv_reg1, 8'h00);
        check_output("mid_rst_wr_pulse", wr_pulse, 1'b0);
        check_output("mid_rst_wr_addr", wr_addr, 2'd0);
        check_output("mid_rst_busy", busy, 1'b0);
        check_output("mid_rst_miso_oe", miso_oe, 1'b0);
        check_output("mid_rst_miso", miso, 1'b0);
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        #30 reset = 1'b1;
        #40;
        spi_bits(8'h82, 8, rx);
        spi_bits(8'h77, 8, rx);
        #20 ss_n = 1'b1;
        #100;
        check_output("no_resume_slv_reg2", slv_reg2, 8'h00);
        check_output("no_resume_wr", wr_seen, 6);
        frame_q = {8'h12};
        apply_stimulus(1'b1, 2'd0, 1, 0);
        check_output("post_reset_slv_reg0", slv_reg0, 8'h12);
        check_regs();

        // Random read/write frames.
        for (int f = 0; f < 200; f++) begin
            int n;
            logic w;
            n = $urandom_range(1, 2);
            w = 1'($urandom);
            frame_q = {8'($urandom), 8'($urandom)};
            apply_stimulus(w, 2'($urandom), n, 0);
        end
        check_regs();

        for (int k = 0; k < 50 && (exp_wr.size() > 0 || rd_obs.size() > 0); k++) @(negedge clk);
        check_output("wr_queue_drained", exp_wr.size(), 0);
        check_output("rd_queue_drained", rd_exp.size(), 0);
        check_output("wr_pulse_total", wr_seen, exp_wr_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
